result_writer: RTL

//  Write-back end of the signed Dadda multiplier datapath. The operand fetch side reads packed {b,a} words from the

---
 rtl/mult_pkg.sv | 30 +++
 rtl/valid_delay_line.sv | 47 ++++
 rtl/result_writer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the signed Dadda multiplier datapath: default widths,
// the write-back state encoding, and small helpers for inspecting products.
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

  // Write-back controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FULL  = 2'd3
  } wr_state_t;

  // True when a two's-complement product is negative.
  function automatic logic prod_is_neg(input logic [DEF_DATA_W-1:0] p);
    return p[DEF_DATA_W-1];
  endfunction

  // Magnitude of a two's-complement product. The most negative value maps
  // onto itself, which is the expected wrap for a fixed-width magnitude.
  function automatic logic [DEF_DATA_W-1:0] prod_magnitude(input logic [DEF_DATA_W-1:0] p);
    return p[DEF_DATA_W-1] ? (~p + 1'b1) : p;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// -----------------------------------------------------------------------------
// valid_delay_line
// Shift register that delays a run/pause strobe by LAT cycles so that it can
// mark which cycles carry a valid pipeline result. Shared by the fetch side and
// the write-back side.
//
// Ports
//   i_clk    clock, posedge
//   i_rst_n  synchronous reset, active-low; empties the line
//   i_clear  synchronous flush; empties the line
//   i_din    strobe sampled every cycle
//   o_tap    strobe delayed by LAT cycles (oldest stage)
//   o_any    at least one stage holds a 1 (results still in flight)
// -----------------------------------------------------------------------------
module valid_delay_line #(
  parameter int LAT = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_din,
  output logic o_tap,
  output logic o_any
);

  logic [LAT-1:0] r_pipe;

  generate
    if (LAT == 1) begin : g_single
      always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) r_pipe <= '0;
        else                     r_pipe <= i_din;
      end
    end else begin : g_multi
      // NOTE: non-blocking assignments let every stage see the previous value
      // of its neighbour, so the shift happens as one parallel step per edge.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) r_pipe <= '0;
        else                     r_pipe <= {r_pipe[LAT-2:0], i_din};
      end
    end
  endgenerate

  assign o_tap = r_pipe[LAT-1];
  assign o_any = |r_pipe;

endmodule

// File: rtl/result_writer.sv
// -----------------------------------------------------------------------------
// result_writer
// Write-back end of the signed multiplier datapath. Products arriving from the
// multiplier are written, unmodified, into result BRAM port B at sequential
// addresses starting at 0. The fetch side's start_stop strobe is delayed by the
// multiplier latency to tell which cycles carry a valid product.
//
// Parameters
//   ADDR_W    result BRAM address width (capacity 2**ADDR_W words)
//   DATA_W    product / BRAM word width
//   PIPE_LAT  cycles from start_stop sampled high to its product (1..8)
//   WRAP      0: stop in FULL at capacity; 1: wrap address and keep writing
//
// Ports
//   clka        clock, posedge
//   rst         synchronous reset, active-low
//   start_stop  run/pause strobe shared with the fetch side
//   clear       synchronous restart (pointer, delay line, state; data held)
//   product     signed product, valid only in a tap cycle
//   addrb/enb/web/dinb  registered BRAM port B write interface
//   wr_count    products written since reset/clear, saturating at 2**ADDR_W
//   busy        controller is in RUN or DRAIN
//   full        controller is in FULL
//   done        one-cycle pulse on DRAIN->IDLE or on entering FULL
// -----------------------------------------------------------------------------
module result_writer
  import mult_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PIPE_LAT = 2,
  parameter bit WRAP     = 1'b0
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start_stop,
  input  logic              clear,
  input  logic [DATA_W-1:0] product,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  output logic              web,
  output logic [DATA_W-1:0] dinb,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              full,
  output logic              done
);

  localparam logic [ADDR_W:0] CAP    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CAP_M1 = CAP - 1'b1;

  wr_state_t         r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_addrb;
  logic              r_enb;
  logic [DATA_W-1:0] r_dinb;
  logic              r_done;

  wr_state_t w_next;
  logic      w_done;
  logic      w_tap;
  logic      w_any;
  logic      w_wr;
  logic      w_last;

  valid_delay_line #(
    .LAT (PIPE_LAT)
  ) u_vpipe (
    .i_clk   (clka),
    .i_rst_n (rst),
    .i_clear (clear),
    .i_din   (start_stop),
    .o_tap   (w_tap),
    .o_any   (w_any)
  );

  // A tap carries a product; once FULL, further products are dropped.
  assign w_wr   = w_tap && (r_state != FULL);
  // The write that fills the last free word ends the run when not wrapping.
  assign w_last = w_wr && !WRAP && (r_count == CAP_M1);

  always_comb begin
    // NOTE: every output of this block is given a default before the case so
    // no path leaves a value unassigned, which would otherwise infer a latch.
    w_next = r_state;
    w_done = 1'b0;
    unique case (r_state)
      IDLE:  if (start_stop) w_next = RUN;
      RUN:   if (!start_stop) w_next = DRAIN;
      DRAIN: begin
        if (start_stop) begin
          w_next = RUN;
        end else if (!w_any) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      FULL:    w_next = FULL;
      default: w_next = IDLE;
    endcase
    if (w_last) begin
      w_next = FULL;
      w_done = 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_addrb <= '0;
      r_enb   <= 1'b0;
      r_dinb  <= '0;
      r_done  <= 1'b0;
    end else if (clear) begin
      // NOTE: clear restarts control only; the last address and data stay on
      // the BRAM port, since with enb low they are never consumed anyway.
      r_state <= IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_enb   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      r_enb   <= w_wr;
      if (w_wr) begin
        r_addrb <= r_ptr;
        r_dinb  <= product;
        // The pointer wraps naturally at 2**ADDR_W; without WRAP the FULL
        // state stops writes before the wrapped pointer is ever used.
        r_ptr   <= r_ptr + 1'b1;
        if (r_count != CAP) r_count <= r_count + 1'b1;
      end
    end
  end

  assign addrb    = r_addrb;
  assign enb      = r_enb;
  assign web      = r_enb;
  assign dinb     = r_dinb;
  assign wr_count = r_count;
  assign busy     = (r_state == RUN) || (r_state == DRAIN);
  assign full     = (r_state == FULL);
  assign done     = r_done;

endmodule
